// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM memory responder: FSM encoding,
// the default memory-mapped I/O address and the byte-lane count.
package arm_mem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0000_0400;
    localparam int          LANES           = 4;

endpackage

// File: rtl/arm_mem_responder_word_assembler.sv
// Packs the incoming little-endian byte stream into 32-bit words.
// The word output is the current assembly merged with the byte being
// accepted this cycle, so the top can commit it on the same edge that
// word_done is high. Lanes above the current byte are always zero.
module word_assembler
    import arm_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    input  logic        last,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  cnt;
    logic [31:0] asm_reg;

    assign word      = asm_reg | ({24'd0, byte_in} << {cnt, 3'b000});
    assign word_done = accept && ((cnt == 2'(LANES - 1)) || last);

    // Advance the byte counter and keep the partial word; restart after each completed word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            asm_reg <= '0;
        end else if (accept) begin
            if (word_done) begin
                cnt     <= '0;
                asm_reg <= '0;
            end else begin
                cnt     <= cnt + 2'd1;
                asm_reg <= word;
            end
        end
    end

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder for the multicycle ARM core: unified word memory,
// one memory-mapped output register and a byte-stream boot loader that
// holds the core in reset until the image has been received.
// Optional build macro ARM_MEM_LOAD_CHECKSUM_EN enables the running
// modulo-256 checksum on load_sum; otherwise load_sum is tied to zero.
module arm_mem_responder
    import arm_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_ready,
    output logic        core_reset,
    output logic [31:0] io_out,
    output logic        load_ovf,
    output logic [7:0]  load_sum
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

    state_t        state;
    logic [AW-1:0] ptr;
    logic          full;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic [31:0]   asm_word;
    logic          word_done;
    logic [AW-1:0] core_idx;
    logic          in_range;
    logic          is_io;
    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdata;

    assign accept     = load_valid && (state == LOAD);
    assign load_ready = (state == LOAD);
    assign core_idx   = Adr[AW+1:2];
    assign in_range   = (Adr < MEM_BYTES);
    assign is_io      = (Adr == IO_ADDR);

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .byte_in   (load_byte),
        .last      (load_last),
        .word      (asm_word),
        .word_done (word_done)
    );

    // Boot loader / run FSM with registered core reset, overflow flag and MMIO register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LOAD;
            ptr        <= '0;
            full       <= 1'b0;
            load_ovf   <= 1'b0;
            core_reset <= 1'b1;
            io_out     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (word_done) begin
                            if (full) begin
                                load_ovf <= 1'b1;
                            end else if (ptr == LAST_PTR) begin
                                full <= 1'b1;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end
                        if (load_last) begin
                            state      <= RUN;
                            core_reset <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (MemWrite && is_io) begin
                        io_out <= WriteData;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Select the single memory write port source: loader during LOAD, core during RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = ptr;
        mem_wdata = asm_word;
        if (state == LOAD) begin
            mem_we = word_done && !full;
        end else if (MemWrite && in_range && !is_io) begin
            mem_we    = 1'b1;
            mem_idx   = core_idx;
            mem_wdata = WriteData;
        end
    end

    // Memory array is never cleared by reset so a reloaded image can overlay old contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    // Combinational core read path; the core sees zero while it is held in reset.
    always_comb begin
        ReadData = '0;
        if (state == RUN) begin
            if (is_io) begin
                ReadData = io_out;
            end else if (in_range) begin
                ReadData = mem[core_idx];
            end
        end
    end

`ifdef ARM_MEM_LOAD_CHECKSUM_EN
    // Running sum of every accepted byte, including dropped overflow bytes; frozen once in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_sum <= '0;
        end else if (accept) begin
            load_sum <= load_sum + load_byte;
        end
    end
`else
    assign load_sum = '0;
`endif

endmodule

// File: tb/tb_arm_mem_responder.sv
// Directed self-checking bench for arm_mem_responder.
module tb_arm_mem_responder;
    import arm_mem_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] IOA   = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        core_reset;
    logic [31:0] io_out;
    logic        load_ovf;
    logic [7:0]  load_sum;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_sum;

    arm_mem_responder #(.DEPTH_WORDS(DEPTH), .IO_ADDR(IOA)) dut (
        .clk        (clk),
        .reset      (reset),
        .Adr        (Adr),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .ReadData   (ReadData),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .load_ready (load_ready),
        .core_reset (core_reset),
        .io_out     (io_out),
        .load_ovf   (load_ovf),
        .load_sum   (load_sum)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_byte  = '0;
        MemWrite   = 1'b0;
        Adr        = '0;
        WriteData  = '0;
        exp_sum    = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge clk);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        exp_sum    = exp_sum + b;
    endtask

    task automatic set_adr(input logic [31:0] a);
        @(negedge clk);
        Adr = a;
        #1;
    endtask

    task automatic core_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Adr       = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (core_reset !== 1'b1 || load_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: core_reset=%b load_ready=%b, required 1/1", core_reset, load_ready);
        end
        vectors++;
        if (io_out !== 32'h0 || load_ovf !== 1'b0 || load_sum !== 8'h0 || ReadData !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outs: io_out=%h ovf=%b sum=%h rd=%h, required 0", io_out, load_ovf, load_sum, ReadData);
        end
        core_write(IOA, 32'hFFFF_FFFF);
        vectors++;
        if (io_out !== 32'h0 || ReadData !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL load_ignores_core: io_out=%h rd=%h, required 0/0", io_out, ReadData);
        end
    endtask

    task automatic test_load_basic();
        logic [7:0] img [8];
        img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i], i == 7);
            if (i == 6) begin
                vectors++;
                if (core_reset !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL still_loading: core_reset=%b, required 1", core_reset);
                end
            end
        end
        vectors++;
        if (core_reset !== 1'b0 || load_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL run_entry: core_reset=%b load_ready=%b, required 0/0", core_reset, load_ready);
        end
        set_adr(32'h0);
        vectors++;
        if (ReadData !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL basic_word0: got %h, required 12345678", ReadData);
        end
        set_adr(32'h4);
        vectors++;
        if (ReadData !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("[TB] FAIL basic_word1: got %h, required deadbeef", ReadData);
        end
`ifdef ARM_MEM_LOAD_CHECKSUM_EN
        vectors++;
        if (load_sum !== exp_sum) begin
            miscompares++;
            $display("[TB] FAIL basic_sum: got %h, required %h", load_sum, exp_sum);
        end
`endif
    endtask

    task automatic test_partial();
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        @(negedge clk);
        load_last = 1'b1;
        @(posedge clk);
        #1;
        load_last = 1'b0;
        vectors++;
        if (core_reset !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL last_without_valid: core_reset=%b, required 1", core_reset);
        end
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b1);
        set_adr(32'h0);
        vectors++;
        if (ReadData !== 32'h0403_0201) begin
            miscompares++;
            $display("[TB] FAIL partial_word0: got %h, required 04030201", ReadData);
        end
        set_adr(32'h4);
        vectors++;
        if (ReadData !== 32'h0000_0005) begin
            miscompares++;
            $display("[TB] FAIL partial_word1: got %h, required 00000005", ReadData);
        end
    endtask

    task automatic test_mmio();
        core_write(IOA, 32'hA5A5_0001);
        vectors++;
        if (io_out !== 32'hA5A5_0001) begin
            miscompares++;
            $display("[TB] FAIL mmio_out: got %h, required a5a50001", io_out);
        end
        set_adr(IOA);
        vectors++;
        if (ReadData !== 32'hA5A5_0001) begin
            miscompares++;
            $display("[TB] FAIL mmio_read: got %h, required a5a50001", ReadData);
        end
    endtask

    task automatic test_back_to_back();
        core_write(32'h8, 32'h0000_1111);
        @(negedge clk);
        Adr       = 32'h8;
        WriteData = 32'h0000_CAFE;
        MemWrite  = 1'b1;
        #1;
        vectors++;
        if (ReadData !== 32'h0000_1111) begin
            miscompares++;
            $display("[TB] FAIL rdw_old: got %h, required 00001111", ReadData);
        end
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        vectors++;
        if (ReadData !== 32'h0000_CAFE) begin
            miscompares++;
            $display("[TB] FAIL rdw_new: got %h, required 0000cafe", ReadData);
        end
        core_write(32'h0000_1000, 32'h0BAD_0BAD);
        vectors++;
        if (ReadData !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL oor_read: got %h, required 0", ReadData);
        end
        set_adr(32'h0);
        vectors++;
        if (ReadData !== 32'h0403_0201) begin
            miscompares++;
            $display("[TB] FAIL oor_word0: got %h, required 04030201", ReadData);
        end
        set_adr(32'h4);
        vectors++;
        if (ReadData !== 32'h0000_0005) begin
            miscompares++;
            $display("[TB] FAIL oor_word1: got %h, required 00000005", ReadData);
        end
        set_adr(32'h8);
        vectors++;
        if (ReadData !== 32'h0000_CAFE) begin
            miscompares++;
            $display("[TB] FAIL oor_word2: got %h, required 0000cafe", ReadData);
        end
        vectors++;
        if (io_out !== 32'hA5A5_0001) begin
            miscompares++;
            $display("[TB] FAIL oor_io: got %h, required a5a50001", io_out);
        end
    endtask

    task automatic test_overflow();
        int n;
        logic [7:0] b;
        n = 4 * DEPTH + 4;
        do_reset();
        for (int i = 0; i < n; i++) begin
            b = (i < 256) ? 8'(i) : 8'(8'hA0 + (i - 256));
            send_byte(b, i == n - 1);
        end
        vectors++;
        if (load_ovf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovf_flag: got %b, required 1", load_ovf);
        end
        set_adr(32'h0);
        vectors++;
        if (ReadData !== 32'h0302_0100) begin
            miscompares++;
            $display("[TB] FAIL ovf_word0: got %h, required 03020100", ReadData);
        end
        set_adr(32'(4 * (DEPTH - 1)));
        vectors++;
        if (ReadData !== 32'hFFFE_FDFC) begin
            miscompares++;
            $display("[TB] FAIL ovf_lastword: got %h, required fffefdfc", ReadData);
        end
`ifdef ARM_MEM_LOAD_CHECKSUM_EN
        vectors++;
        if (load_sum !== exp_sum) begin
            miscompares++;
            $display("[TB] FAIL ovf_sum: got %h, required %h", load_sum, exp_sum);
        end
`else
        vectors++;
        if (load_sum !== 8'h0) begin
            miscompares++;
            $display("[TB] FAIL sum_tied: got %h, required 00", load_sum);
        end
`endif
    endtask

    task automatic test_reset_midload();
        set_adr(32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (core_reset !== 1'b1 || ReadData !== 32'h0 || load_ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL run_reset: core_reset=%b rd=%h ovf=%b, required 1/0/0", core_reset, ReadData, load_ovf);
        end
        do_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (core_reset !== 1'b1 || load_ready !== 1'b1 || load_sum !== 8'h0) begin
            miscompares++;
            $display("[TB] FAIL midload_reset: core_reset=%b ready=%b sum=%h, required 1/1/00", core_reset, load_ready, load_sum);
        end
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b1);
        set_adr(32'h0);
        vectors++;
        if (ReadData !== 32'hDDCC_BBAA) begin
            miscompares++;
            $display("[TB] FAIL reload_word0: got %h, required ddccbbaa", ReadData);
        end
    endtask

    initial begin
        reset      = 1'b1;
        Adr        = '0;
        WriteData  = '0;
        MemWrite   = 1'b0;
        load_valid = 1'b0;
        load_byte  = '0;
        load_last  = 1'b0;
        exp_sum    = '0;
        test_reset();
        test_load_basic();
        test_partial();
        test_mmio();
        test_back_to_back();
        test_overflow();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
